// File: rtl/comp_sweep_driver_if.sv
// Operand/result bus between the sweep driver and a magnitude comparator.
interface comp_sweep_driver_if #(parameter int WIDTH = 2);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             agreaterb_i;
  logic             aequalb_i;
  logic             alesserb_i;

  modport master (output a_o, b_o, input agreaterb_i, aequalb_i, alesserb_i);
  modport slave  (input a_o, b_o, output agreaterb_i, aequalb_i, alesserb_i);
endinterface

// File: rtl/comp_sweep_driver.sv
// Built-in self-test engine: sweeps every operand pair into a magnitude
// comparator, checks its flags against a reference and reports the result.
module comp_sweep_driver #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  comp_sweep_driver_if.master   cmp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH:0]      err_count,
  output logic                  first_err_valid,
  output logic [WIDTH-1:0]      first_err_a,
  output logic [WIDTH-1:0]      first_err_b
);
  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [2:0]      exp_flags, got_flags;
  logic            mism;

  // Operands come straight from the registered sweep index, b fastest.
  assign cmp.a_o = idx[IW-1:WIDTH];
  assign cmp.b_o = idx[WIDTH-1:0];

  assign exp_flags = {cmp.a_o > cmp.b_o, cmp.a_o == cmp.b_o, cmp.a_o < cmp.b_o};
  assign got_flags = {cmp.agreaterb_i, cmp.aequalb_i, cmp.alesserb_i};
  assign mism      = (got_flags != exp_flags);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state           <= SETTLE;
            idx             <= '0;
            cnt             <= CNT_LOAD;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          if (mism) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_a     <= cmp.a_o;
              first_err_b     <= cmp.b_o;
            end
          end
          if (idx == '1) begin
            // pass must account for the pair being checked this cycle
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == '0) && !mism;
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
